// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the round-robin memory arbiter and its owner-ID FIFO.
// Used by mem_arb_rr and mem_arb_owner_fifo.
package mem_arb_pkg;

  localparam int DEF_XLEN      = 32;
  localparam int DEF_NUM_PORTS = 3;
  localparam int DEF_MAX_OUTST = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  // Owner IDs need at least one bit even for a degenerate single-port build.
  function automatic int owner_id_w(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_owner_fifo.sv
// Owner-ID FIFO: remembers which port issued each in-flight memory transaction.
// A push while full is honoured only when a pop happens in the same cycle.
module mem_arb_owner_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic                   full,
  output logic                   empty,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mem_arb_rr.sv
// N-port arbiter onto one memory port: registered request issue, in-order response routing.
// Define MEM_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (port 0 highest).
module mem_arb_rr
  import mem_arb_pkg::*;
#(
  parameter int XLEN      = DEF_XLEN,
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int MAX_OUTST = DEF_MAX_OUTST
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          s_valid,
  output logic [NUM_PORTS-1:0]          s_ready,
  input  logic [NUM_PORTS-1:0]          s_we,
  input  logic [NUM_PORTS*XLEN-1:0]     s_addr,
  input  logic [NUM_PORTS*XLEN-1:0]     s_wdata,
  input  logic [NUM_PORTS*(XLEN/8)-1:0] s_wstrb,
  output logic [NUM_PORTS-1:0]          s_rsp_valid,
  output logic [XLEN-1:0]               s_rsp_rdata,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_we,
  output logic [XLEN-1:0]               m_addr,
  output logic [XLEN-1:0]               m_wdata,
  output logic [XLEN/8-1:0]             m_wstrb,
  input  logic                          m_rsp_valid,
  input  logic [XLEN-1:0]               m_rsp_rdata,
  output logic                          rsp_err
);

  localparam int IDW = owner_id_w(NUM_PORTS);
  localparam int CW  = $clog2(MAX_OUTST) + 1;
  localparam int SW  = XLEN / 8;

  arb_state_e           state_q, state_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic                 m_we_q, m_we_d;
  logic [XLEN-1:0]      m_addr_q, m_addr_d;
  logic [XLEN-1:0]      m_wdata_q, m_wdata_d;
  logic [SW-1:0]        m_wstrb_q, m_wstrb_d;
  logic [NUM_PORTS-1:0] s_rsp_valid_q, s_rsp_valid_d;
  logic [XLEN-1:0]      s_rsp_rdata_q, s_rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [IDW-1:0]       fifo_head;
  logic [CW-1:0]        fifo_count;
  logic [CW:0]          cnt_post;
  logic                 room, grant_en, accept;
  logic                 win_found;
  logic [IDW-1:0]       win_idx;
  logic                 sel_we;
  logic [XLEN-1:0]      sel_addr, sel_wdata;
  logic [SW-1:0]        sel_wstrb;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
`endif

  assign fifo_push = (state_q == ISSUE) && m_ready;
  assign fifo_pop  = m_rsp_valid && !fifo_empty;

  // In ISSUE the room check sees the count as it will be after this cycle's push/pop,
  // which is what lets a new request be granted in the same cycle as the handshake.
  assign cnt_post = {1'b0, fifo_count} + {{CW{1'b0}}, fifo_push} - {{CW{1'b0}}, fifo_pop};
  assign room     = (state_q == IDLE) ? !fifo_full : (cnt_post < (CW+1)'(MAX_OUTST));
  assign grant_en = rst_n && ((state_q == IDLE) || m_ready);
  assign accept   = grant_en && win_found && room;

`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (s_valid[i]) begin
        win_found = 1'b1;
        win_idx   = IDW'(i);
      end
    end
  end
`else
  always_comb begin : p_rr_winner
    logic [IDW:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_PORTS)) cand = cand - (IDW+1)'(NUM_PORTS);
      if (!win_found && s_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end
`endif

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (win_idx == IDW'(i)) begin
        sel_we    = s_we[i];
        sel_addr  = s_addr[i*XLEN +: XLEN];
        sel_wdata = s_wdata[i*XLEN +: XLEN];
        sel_wstrb = s_wstrb[i*SW +: SW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    s_ready   = '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
    rr_ptr_d  = rr_ptr_q;
`endif
    if (accept) begin
      s_ready[win_idx] = 1'b1;
      state_d          = ISSUE;
      owner_d          = win_idx;
      m_we_d           = sel_we;
      m_addr_d         = sel_addr;
      m_wdata_d        = sel_wdata;
      m_wstrb_d        = sel_wstrb;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_ptr_d = (win_idx == IDW'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
`endif
    end else if ((state_q == ISSUE) && m_ready) begin
      state_d = IDLE;
    end
  end

  // Responses come back in issue order; a response with nothing outstanding is dropped.
  always_comb begin
    s_rsp_valid_d = '0;
    s_rsp_rdata_d = s_rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    if (m_rsp_valid) begin
      if (fifo_empty) begin
        rsp_err_d = 1'b1;
      end else begin
        s_rsp_valid_d[fifo_head] = 1'b1;
        s_rsp_rdata_d            = m_rsp_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      m_we_q        <= 1'b0;
      m_addr_q      <= '0;
      m_wdata_q     <= '0;
      m_wstrb_q     <= '0;
      s_rsp_valid_q <= '0;
      s_rsp_rdata_q <= '0;
      rsp_err_q     <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_ptr_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      m_we_q        <= m_we_d;
      m_addr_q      <= m_addr_d;
      m_wdata_q     <= m_wdata_d;
      m_wstrb_q     <= m_wstrb_d;
      s_rsp_valid_q <= s_rsp_valid_d;
      s_rsp_rdata_q <= s_rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_ptr_q      <= rr_ptr_d;
`endif
    end
  end

  mem_arb_owner_fifo #(
    .WIDTH (IDW),
    .DEPTH (MAX_OUTST)
  ) u_owner_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (owner_q),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head),
    .count (fifo_count)
  );

  assign m_valid     = (state_q == ISSUE);
  assign m_we        = m_we_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign m_wstrb     = m_wstrb_q;
  assign s_rsp_valid = s_rsp_valid_q;
  assign s_rsp_rdata = s_rsp_rdata_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_mem_arb_rr.sv
// Directed bench for mem_arb_rr: memory model plus grant/response scoreboards.
// Expected grant order follows MEM_ARB_FIXED_PRIO_EN when it is defined.
module tb_mem_arb_rr;

  logic         clk;
  logic         rst_n;
  logic [2:0]   s_valid;
  logic [2:0]   s_ready;
  logic [2:0]   s_we;
  logic [95:0]  s_addr;
  logic [95:0]  s_wdata;
  logic [11:0]  s_wstrb;
  logic [2:0]   s_rsp_valid;
  logic [31:0]  s_rsp_rdata;
  logic         m_valid;
  logic         m_ready;
  logic         m_we;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [3:0]   m_wstrb;
  logic         m_rsp_valid;
  logic [31:0]  m_rsp_rdata;
  logic         rsp_err;

  typedef struct {
    int          port;
    logic [31:0] data;
  } rsp_t;

  rsp_t        exp_rsp[$];
  logic [31:0] exp_hs[$];
  logic [31:0] mem_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  int          n_fail  = 0;
  int          ptr_m   = 0;
  logic        auto_rsp, man_rsp, pipe0, pipe1;

  mem_arb_rr #(.XLEN(32), .NUM_PORTS(3), .MAX_OUTST(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_we        (s_we),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_rsp_valid (s_rsp_valid),
    .s_rsp_rdata (s_rsp_rdata),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_we        (m_we),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_wstrb     (m_wstrb),
    .m_rsp_valid (m_rsp_valid),
    .m_rsp_rdata (m_rsp_rdata),
    .rsp_err     (rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hDEADBFEF;
  endfunction

  function automatic int model_win(input logic [2:0] v, input int ptr);
    int w;
    w = -1;
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = 2; i >= 0; i--) if (v[i]) w = i;
    if (ptr < 0) w = -1;
`else
    for (int k = 2; k >= 0; k--) if (v[(ptr + k) % 3]) w = (ptr + k) % 3;
`endif
    return w;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] st);
    s_we[p]          = we;
    s_addr[p*32 +: 32]  = a;
    s_wdata[p*32 +: 32] = d;
    s_wstrb[p*4 +: 4]   = st;
  endtask

  task automatic expect_accept(input string tag);
    int          w;
    logic [31:0] a;
    w = model_win(s_valid, ptr_m);
    if (w < 0) w = 0;
    chk(tag, 128'(s_ready), 128'(3'b001 << w));
    a = s_addr[w*32 +: 32];
    ptr_m = (w + 1) % 3;
    exp_hs.push_back(a);
    exp_rsp.push_back('{port: w, data: memf(a)});
  endtask

  task automatic expect_no_accept(input string tag);
    chk(tag, 128'(s_ready), 128'(0));
  endtask

  // One clock: grant-address check at the handshake, memory model, response check.
  task automatic tick();
    logic        hs, rv;
    logic [31:0] ha;
    rsp_t        e;
    hs = m_valid && m_ready;
    ha = m_addr;
    if (hs) begin
      if (exp_hs.size() == 0) chk("hs_unexpected", 128'(m_valid), 128'(0));
      else chk("grant_addr", 128'(ha), 128'(exp_hs.pop_front()));
      mem_q.push_back(ha);
    end
    @(posedge clk);
    #1;
    rv    = auto_rsp ? pipe1 : 1'b0;
    pipe1 = auto_rsp ? pipe0 : 1'b0;
    pipe0 = auto_rsp && hs;
    if (man_rsp) rv = 1'b1;
    man_rsp     = 1'b0;
    m_rsp_valid = rv;
    if (rv) m_rsp_rdata = (mem_q.size() > 0) ? memf(mem_q.pop_front()) : 32'hBAD0BAD0;
    else    m_rsp_rdata = 32'h0;
    @(negedge clk);
    if (s_rsp_valid != 3'b000) begin
      if (exp_rsp.size() == 0) begin
        chk("rsp_unexpected", 128'(s_rsp_valid), 128'(0));
      end else begin
        e = exp_rsp.pop_front();
        chk("rsp_port", 128'(s_rsp_valid), 128'(3'b001 << e.port));
        chk("rsp_data", 128'(s_rsp_rdata), 128'(e.data));
      end
    end
  endtask

  task automatic default_ports();
    set_port(0, 1'b0, 32'h000, 32'h0, 4'h0);
    set_port(1, 1'b0, 32'h100, 32'h0, 4'h0);
    set_port(2, 1'b0, 32'h200, 32'h0, 4'h0);
  endtask

  initial begin
    logic got;
    rst_n = 1'b0; s_valid = '0; s_we = '0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
    m_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_rdata = '0;
    auto_rsp = 1'b0; man_rsp = 1'b0; pipe0 = 1'b0; pipe1 = 1'b0;
    default_ports();

    // Reset: outputs stay 0 even with requests pending
    s_valid = 3'b111;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", 128'({s_ready, s_rsp_valid, s_rsp_rdata, m_valid, m_we, m_addr,
                               m_wdata, m_wstrb, rsp_err}), 128'(0));
    s_valid = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;

    // All ports requesting, two-cycle memory
    auto_rsp = 1'b1; m_ready = 1'b1; s_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      expect_accept("rr_grant");
      tick();
      if (k == 0) chk("lat_m_valid", 128'(m_valid), 128'(1));
    end
    s_valid = 3'b000;
    repeat (8) tick();
    chk("rr_rsp_drained", 128'(exp_rsp.size()), 128'(0));
    chk("rr_hs_drained", 128'(exp_hs.size()), 128'(0));

    // Write held under m_ready backpressure
    set_port(2, 1'b1, 32'h40, 32'h12345678, 4'hF);
    s_valid = 3'b100; m_ready = 1'b0;
    #1;
    expect_accept("wr_grant");
    tick();
    s_valid = 3'b000;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) m_ready = 1'b1;
      #1;
      chk("wr_hold", 128'({m_valid, m_we, m_addr, m_wdata, m_wstrb}),
          128'({1'b1, 1'b1, 32'h40, 32'h12345678, 4'hF}));
      tick();
    end
    #1;
    chk("wr_done_idle", 128'(m_valid), 128'(0));
    repeat (6) tick();
    chk("wr_rsp_drained", 128'(exp_rsp.size()), 128'(0));
    default_ports();

    // FIFO full: four issued, fifth waits for a response; push+pop keeps occupancy
    auto_rsp = 1'b0; m_ready = 1'b1; s_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      #1;
      expect_accept("full_fill");
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      #1;
      expect_no_accept("full_block");
      tick();
    end
    man_rsp = 1'b1;
    #1;
    expect_no_accept("full_block_rsp");
    tick();
    got = 1'b0;
    for (int w = 0; w < 4; w++) begin
      #1;
      if (s_ready != 3'b000) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    if (!got) #1;
    expect_accept("full_release");
    man_rsp = 1'b1;
    tick();
    #1;
    expect_accept("pushpop_grant");
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      expect_no_accept("refull_block");
      tick();
    end
    s_valid = 3'b000;
    repeat (4) begin
      man_rsp = 1'b1;
      tick();
      tick();
    end
    repeat (2) tick();
    chk("full_rsp_drained", 128'(exp_rsp.size()), 128'(0));

    // Response with nothing outstanding
    #1;
    chk("err_clear", 128'(rsp_err), 128'(0));
    man_rsp = 1'b1;
    tick();
    tick();
    chk("err_no_rsp", 128'(s_rsp_valid), 128'(0));
    chk("err_set", 128'(rsp_err), 128'(1));
    repeat (3) tick();
    chk("err_sticky", 128'(rsp_err), 128'(1));

    // Async reset in ISSUE with two outstanding
    m_ready = 1'b1; s_valid = 3'b111;
    for (int k = 0; k < 3; k++) begin
      #1;
      expect_accept("rst_fill");
      tick();
    end
    s_valid = 3'b000; m_ready = 1'b0;
    #1;
    chk("rst_pre_issue", 128'(m_valid), 128'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_zero", 128'({s_ready, s_rsp_valid, s_rsp_rdata, m_valid, m_we, m_addr,
                                m_wdata, m_wstrb, rsp_err}), 128'(0));
    tick();
    rst_n = 1'b1;
    exp_rsp.delete();
    exp_hs.delete();
    ptr_m = 0;
    man_rsp = 1'b1;
    tick();
    tick();
    chk("rst_late_rsp_err", 128'(rsp_err), 128'(1));
    mem_q.delete();
    pipe0 = 1'b0; pipe1 = 1'b0;

    // Ports 0 and 2 contending
    auto_rsp = 1'b1; m_ready = 1'b1; s_valid = 3'b101;
    for (int k = 0; k < 4; k++) begin
      #1;
      expect_accept("p02_grant");
      tick();
    end
    s_valid = 3'b000;
    repeat (8) tick();
    chk("p02_rsp_drained", 128'(exp_rsp.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
